// File: rtl/uart_pkg.sv
// Shared UART definitions: baud configuration FSM states, legal prescale
// values and the prescale validity check.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARB       = 3'd1,
    WAIT_IDLE = 3'd2,
    HOLD      = 3'd3,
    ACK       = 3'd4,
    REJECT    = 3'd5
  } baud_cfg_state_t;

  localparam int unsigned SAMPL8  = 8;
  localparam int unsigned SAMPL16 = 16;
  localparam int unsigned SAMPL32 = 32;

  function automatic logic is_valid_prescale(input int unsigned v);
    return (v == SAMPL8) || (v == SAMPL16) || (v == SAMPL32);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter; search starts at the requester after ptr.
// The pointer register is owned by the caller.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               vld
);

  int unsigned        cand;
  logic [IDX_W-1:0]   c_idx;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    vld   = 1'b0;
    cand  = 0;
    c_idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand  = (int'(ptr) + i) % NUM_REQ;
      c_idx = IDX_W'(cand);
      if (!vld && req[c_idx]) begin
        vld        = 1'b1;
        idx        = c_idx;
        gnt[c_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/baud_cfg_ctrl.sv
// Baud-rate configuration controller: arbitrates prescale changes and applies
// them only while Tx/Rx are idle, holding the baud generator in reset to settle.
module baud_cfg_ctrl
  import uart_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int PRESCALE_W    = 6,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUM_REQ-1:0]           i_req,
  input  logic [NUM_REQ*PRESCALE_W-1:0] i_req_prescale,
  input  logic                         i_tx_busy,
  input  logic                         i_rx_busy,
  output logic [PRESCALE_W-1:0]        o_prescale,
  output logic                         o_baud_rst_n,
  output logic                         o_cfg_busy,
  output logic [NUM_REQ-1:0]           o_grant,
  output logic [NUM_REQ-1:0]           o_reject
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  baud_cfg_state_t      state;
  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     idx_q;
  logic [NUM_REQ-1:0]   oh_q;
  logic [PRESCALE_W-1:0] val_q;
  logic [CNT_W-1:0]     cnt;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_vld;
  logic [PRESCALE_W-1:0] arb_val;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req (i_req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .vld (arb_vld)
  );

  assign arb_val = i_req_prescale[arb_idx*PRESCALE_W +: PRESCALE_W];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      ptr          <= IDX_W'(NUM_REQ - 1);
      idx_q        <= '0;
      oh_q         <= '0;
      val_q        <= '0;
      cnt          <= '0;
      o_prescale   <= PRESCALE_W'(SAMPL8);
      o_baud_rst_n <= 1'b1;
      o_cfg_busy   <= 1'b0;
      o_grant      <= '0;
      o_reject     <= '0;
    end else begin
      o_grant  <= '0;
      o_reject <= '0;
      case (state)
        IDLE: if (arb_vld) begin
          idx_q <= arb_idx;
          oh_q  <= arb_gnt;
          val_q <= arb_val;
          state <= ARB;
        end
        ARB: begin
          if (!is_valid_prescale(32'(val_q))) begin
            o_reject <= oh_q;
            state    <= REJECT;
          end else if (val_q == o_prescale) begin
            o_grant <= oh_q;
            state   <= ACK;
          end else begin
            o_cfg_busy <= 1'b1;
            state      <= WAIT_IDLE;
          end
        end
        // A withdrawn request wins over a simultaneous idle link: nothing is applied.
        WAIT_IDLE: begin
          if (!i_req[idx_q]) begin
            o_cfg_busy <= 1'b0;
            state      <= IDLE;
          end else if (!i_tx_busy && !i_rx_busy) begin
            o_prescale   <= val_q;
            o_baud_rst_n <= 1'b0;
            cnt          <= CNT_W'(SETTLE_CYCLES);
            state        <= HOLD;
          end
        end
        HOLD: begin
          if (cnt == CNT_W'(1)) begin
            o_baud_rst_n <= 1'b1;
            o_cfg_busy   <= 1'b0;
            o_grant      <= oh_q;
            state        <= ACK;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ACK, REJECT: begin
          ptr   <= idx_q;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_baud_cfg_ctrl.sv
// Scoreboard bench for baud_cfg_ctrl: expected grant/reject pulses are queued
// at stimulus time and matched against the DUT pulses.
module tb_baud_cfg_ctrl;

  localparam int N = 2;
  localparam int W = 6;
  localparam int S = 4;

  logic           clk;
  logic           i_rst;
  logic [N-1:0]   i_req;
  logic [N*W-1:0] req_ps;
  logic           tx_busy, rx_busy;
  logic [W-1:0]   o_prescale;
  logic           o_baud_rst_n, o_cfg_busy;
  logic [N-1:0]   o_grant, o_reject;

  baud_cfg_ctrl #(.NUM_REQ(N), .PRESCALE_W(W), .SETTLE_CYCLES(S)) dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_req          (i_req),
    .i_req_prescale (req_ps),
    .i_tx_busy      (tx_busy),
    .i_rx_busy      (rx_busy),
    .o_prescale     (o_prescale),
    .o_baud_rst_n   (o_baud_rst_n),
    .o_cfg_busy     (o_cfg_busy),
    .o_grant        (o_grant),
    .o_reject       (o_reject)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit grant;
    int idx;
    int cyc;
    int ps;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   served[N];
  int   base[N];
  bit   want[N];
  bit   keep_req = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Requester model: a request falls once it has been served, unless held on purpose.
  always_comb begin
    i_req = '0;
    for (int n = 0; n < N; n++)
      i_req[n] = want[n] && (keep_req || served[n] == base[n]);
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (o_grant != '0 || o_reject != '0) begin
      if (sb.size() == 0) begin
        chk("unexp_pulse", int'({o_grant, o_reject}), 0);
      end else begin
        e = sb.pop_front();
        chk("pulse_grant",  int'(o_grant),  e.grant ? (1 << e.idx) : 0);
        chk("pulse_reject", int'(o_reject), e.grant ? 0 : (1 << e.idx));
        chk("pulse_cycle",  cyc, e.cyc);
        chk("pulse_ps",     int'(o_prescale), e.ps);
        served[e.idx]++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic raise(input int n, input int val);
    req_ps[n*W +: W] = W'(val);
    base[n] = served[n];
    want[n] = 1'b1;
  endtask

  task automatic expect_pulse(input bit g, input int n, input int at, input int ps);
    exp_t x;
    x.grant = g; x.idx = n; x.cyc = at; x.ps = ps;
    sb.push_back(x);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      step();
      k++;
    end
    if (sb.size() != 0) chk("sb_timeout", sb.size(), 0);
    step();
  endtask

  int t0;

  initial begin
    for (int n = 0; n < N; n++) begin served[n] = 0; base[n] = 0; want[n] = 1'b0; end
    req_ps = '0; tx_busy = 1'b0; rx_busy = 1'b0; i_rst = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("rst_prescale", int'(o_prescale), 8);
    chk("rst_baud_n",   int'(o_baud_rst_n), 1);
    chk("rst_busy",     int'(o_cfg_busy), 0);
    chk("rst_grant",    int'(o_grant), 0);
    chk("rst_reject",   int'(o_reject), 0);
    step();
    i_rst = 1'b0;

    // Same value: grant at cycle 2 with no reset pulse
    t0 = cyc; raise(0, 8); expect_pulse(1, 0, t0 + 2, 8);
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      chk("same_baud_n", int'(o_baud_rst_n), 1);
    end
    drain(50);

    // Valid change to 16 with Tx/Rx idle
    t0 = cyc; raise(0, 16); expect_pulse(1, 0, t0 + 3 + S, 16);
    for (int c = 0; c <= 3 + S; c++) begin
      @(negedge clk);
      chk("valid_baud_n", int'(o_baud_rst_n), (c >= 3 && c <= 2 + S) ? 0 : 1);
      chk("valid_ps",     int'(o_prescale),   (c >= 3) ? 16 : 8);
      chk("valid_busy",   int'(o_cfg_busy),   (c >= 2 && c <= 2 + S) ? 1 : 0);
    end
    drain(50);

    // Invalid value rejected at cycle 2, prescale untouched
    t0 = cyc; raise(1, 20); expect_pulse(0, 1, t0 + 2, 16);
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      chk("inv_baud_n", int'(o_baud_rst_n), 1);
    end
    drain(50);

    // Contention: both held high, grants alternate starting after last served (1)
    keep_req = 1'b1;
    t0 = cyc; raise(0, 32); raise(1, 16);
    for (int k = 0; k < 4; k++)
      expect_pulse(1, k % 2, t0 + 7 + 8 * k, (k % 2) ? 16 : 32);
    drain(200);
    want[0] = 1'b0; want[1] = 1'b0; keep_req = 1'b0;
    chk("rr_final_ps", int'(o_prescale), 16);
    step();

    // Rx busy for 10 cycles stretches WAIT_IDLE; HOLD starts the cycle after
    t0 = cyc; rx_busy = 1'b1; raise(0, 32); expect_pulse(1, 0, t0 + 11 + S, 32);
    for (int c = 0; c <= 11; c++) begin
      @(negedge clk);
      chk("busy_baud_n", int'(o_baud_rst_n), (c == 11) ? 0 : 1);
      if (c == 10) rx_busy = 1'b0;
    end
    drain(100);

    // Requester drops during WAIT_IDLE: back to IDLE, nothing applied
    tx_busy = 1'b1; raise(1, 8);
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      chk("drop_busy",  int'(o_cfg_busy), (c == 2 || c == 3) ? 1 : 0);
      chk("drop_ps",    int'(o_prescale), 32);
      chk("drop_baud_n", int'(o_baud_rst_n), 1);
      if (c == 3) want[1] = 1'b0;
    end
    tx_busy = 1'b0;
    step();

    // Pointer untouched by the drop: requester 1 still comes first
    t0 = cyc; raise(0, 32); raise(1, 32);
    expect_pulse(1, 1, t0 + 2, 32);
    expect_pulse(1, 0, t0 + 5, 32);
    drain(100);
    want[0] = 1'b0; want[1] = 1'b0;
    step();

    // Reset during HOLD: outputs back to reset values, request re-arbitrated
    t0 = cyc; raise(0, 16);
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      if (c == 4) begin
        chk("hold_baud_n", int'(o_baud_rst_n), 0);
        chk("hold_ps",     int'(o_prescale), 16);
        i_rst = 1'b1;
      end
    end
    chk("mrst_ps",     int'(o_prescale), 8);
    chk("mrst_baud_n", int'(o_baud_rst_n), 1);
    chk("mrst_busy",   int'(o_cfg_busy), 0);
    chk("mrst_grant",  int'(o_grant), 0);
    i_rst = 1'b0;
    expect_pulse(1, 0, cyc + 3 + S, 16);
    drain(100);
    want[0] = 1'b0;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
